// File: rtl/fc_pkg.sv
// Shared definitions for the FC requantisation output stage.
// Optional ReLU fusion is selected with the FC_RELU_EN macro (see fc_requant_lane).
package fc_pkg;

    localparam int unsigned QZ_DEF     = 16;
    localparam int unsigned FRAC_DEF   = 8;
    localparam int unsigned HIDDEN_DEF = 512;

    // Lane geometry: accumulator lanes are twice the width of bias/output lanes
    localparam int unsigned LANES       = 4;
    localparam int unsigned ACC_LANE_MUL = 2;
    localparam int unsigned FIFO_DEPTH  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fc_state_t;

endpackage

// File: rtl/fc_requant_lane.sv
// One lane of bias add, round-half-up, arithmetic shift and signed saturation.
// With FC_RELU_EN defined, negative saturated results are forced to zero.
module fc_requant_lane
    import fc_pkg::*;
#(
    parameter int unsigned QZ   = QZ_DEF,
    parameter int unsigned FRAC = FRAC_DEF
) (
    input  logic [2*QZ-1:0] acc,
    input  logic [QZ-1:0]   bias,
    output logic [QZ-1:0]   res
);

    // Two guard bits keep acc + (bias << FRAC) + half from overflowing
    localparam int unsigned SW = 2 * QZ + 2;
    localparam logic signed [SW-1:0] MAX_V = SW'((1 << (QZ - 1)) - 1);
    localparam logic signed [SW-1:0] MIN_V = ~MAX_V;
    localparam logic signed [SW-1:0] HALF  = SW'(1) << (FRAC - 1);

    logic signed [SW-1:0] acc_x;
    logic signed [SW-1:0] bias_x;
    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] shr;
    logic        [QZ-1:0] sat;

    always_comb begin
        acc_x  = {{(SW - 2 * QZ){acc[2*QZ-1]}}, acc};
        bias_x = {{(SW - QZ){bias[QZ-1]}}, bias};
        sum    = acc_x + (bias_x <<< FRAC) + HALF;
        shr    = sum >>> FRAC;
        if (shr > MAX_V) begin
            sat = MAX_V[QZ-1:0];
        end else if (shr < MIN_V) begin
            sat = MIN_V[QZ-1:0];
        end else begin
            sat = shr[QZ-1:0];
        end
`ifdef FC_RELU_EN
        res = sat[QZ-1] ? '0 : sat;
`else
        res = sat;
`endif
    end

endmodule

// File: rtl/fc_requant_out.sv
// Reads accumulator rows plus bias, requantises four lanes per row and streams rows out.
// ReLU fusion follows FC_RELU_EN (default build: signed saturated output).
module fc_requant_out
    import fc_pkg::*;
#(
    parameter int unsigned HIDDEN     = HIDDEN_DEF,
    parameter int unsigned QZ         = QZ_DEF,
    parameter int unsigned FRAC       = FRAC_DEF,
    parameter int unsigned ADDR_WIDTH = $clog2(HIDDEN * 4)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    output logic [ADDR_WIDTH-1:0]       acc_rd_addr,
    output logic                        acc_rd_en,
    input  logic [ACC_LANE_MUL*LANES*QZ-1:0] acc_data,
    output logic [ADDR_WIDTH-1:0]       bias_rd_addr,
    input  logic [LANES*QZ-1:0]         bias_data,
    output logic [LANES*QZ-1:0]         out_data,
    output logic [ADDR_WIDTH-1:0]       out_row,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        busy,
    output logic                        new_cal,
    output logic                        done
);

    localparam int unsigned DW = LANES * QZ;
    localparam int unsigned AW = ACC_LANE_MUL * QZ;

    fc_state_t             state;
    logic [ADDR_WIDTH-1:0] rd_row;
    logic                  dv;
    logic [ADDR_WIDTH-1:0] dv_row;
    logic [DW-1:0]         res_bus;

    logic [DW-1:0]         fifo_data [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_row  [FIFO_DEPTH];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            cnt;

    logic                  pop;
    logic                  out_free;
    logic                  fifo_rd;
    logic                  load_direct;
    logic                  fifo_wr;
    logic [1:0]            cnt_nxt;
    logic                  can_issue;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        fc_requant_lane #(
            .QZ   (QZ),
            .FRAC (FRAC)
        ) u_lane (
            .acc  (acc_data[AW*i +: AW]),
            .bias (bias_data[QZ*i +: QZ]),
            .res  (res_bus[QZ*i +: QZ])
        );
    end

    assign bias_rd_addr = acc_rd_addr;

    // Output register backed by a 2-entry FIFO; arriving rows bypass the FIFO when it is empty
    always_comb begin
        pop         = out_valid && out_ready;
        out_free    = !out_valid || pop;
        fifo_rd     = out_free && (cnt != 2'd0);
        load_direct = out_free && (cnt == 2'd0) && dv;
        fifo_wr     = dv && !load_direct;
        cnt_nxt     = cnt + 2'(fifo_wr) - 2'(fifo_rd);
        // A stalled output register never blocks: FIFO room covers every read in flight
        can_issue   = (3'(cnt_nxt) + 3'(acc_rd_en)) < 3'd2;
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fifo_data[wr_ptr] <= res_bus;
            fifo_row[wr_ptr]  <= dv_row;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rd_row      <= '0;
            acc_rd_en   <= 1'b0;
            acc_rd_addr <= '0;
            dv          <= 1'b0;
            dv_row      <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            cnt         <= 2'd0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_row     <= '0;
            busy        <= 1'b0;
            new_cal     <= 1'b0;
            done        <= 1'b0;
        end else begin
            done    <= 1'b0;
            new_cal <= 1'b0;

            if (fifo_rd) begin
                out_data  <= fifo_data[rd_ptr];
                out_row   <= fifo_row[rd_ptr];
                out_valid <= 1'b1;
                rd_ptr    <= ~rd_ptr;
            end else if (load_direct) begin
                out_data  <= res_bus;
                out_row   <= dv_row;
                out_valid <= 1'b1;
            end else if (pop) begin
                out_valid <= 1'b0;
            end

            if (fifo_wr) begin
                wr_ptr <= ~wr_ptr;
            end
            cnt    <= cnt_nxt;
            dv     <= acc_rd_en;
            dv_row <= acc_rd_addr;

            case (state)
                IDLE: begin
                    acc_rd_en <= 1'b0;
                    if (start) begin
                        state       <= (HIDDEN == 1) ? DRAIN : RUN;
                        busy        <= 1'b1;
                        acc_rd_en   <= 1'b1;
                        acc_rd_addr <= '0;
                        rd_row      <= ADDR_WIDTH'(1);
                    end
                end
                RUN: begin
                    if (can_issue) begin
                        acc_rd_en   <= 1'b1;
                        acc_rd_addr <= rd_row;
                        rd_row      <= rd_row + ADDR_WIDTH'(1);
                        if (rd_row == ADDR_WIDTH'(HIDDEN - 1)) begin
                            state <= DRAIN;
                        end
                    end else begin
                        acc_rd_en <= 1'b0;
                    end
                end
                DRAIN: begin
                    acc_rd_en <= 1'b0;
                    if (pop && (out_row == ADDR_WIDTH'(HIDDEN - 1))) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        new_cal <= 1'b1;
                    end
                end
                DONE: begin
                    acc_rd_en <= 1'b0;
                    state     <= IDLE;
                    busy      <= 1'b0;
                    rd_row    <= '0;
                end
                default: begin
                    state     <= IDLE;
                    acc_rd_en <= 1'b0;
                end
            endcase
        end
    end

endmodule
